// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared FSM state type and default widths for the SRAM APB initiator.
package cpu_mem_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF = 8;
  localparam int WORD_STRIDE = 4;
endpackage

// File: rtl/cpu_mem_apb_master_if.sv
// cpu_mem_apb_master_if: command, APB and response channels of the SRAM initiator.
interface cpu_mem_apb_master_if
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) ();
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic              i_cmd_write;
  logic [ADDR_W-1:0] i_cmd_addr;
  logic [DATA_W-1:0] i_cmd_wdata;
  logic [LEN_W-1:0]  i_cmd_len;
  logic              o_penable;
  logic              o_pwrite;
  logic [ADDR_W-1:0] o_paddr;
  logic [DATA_W-1:0] o_pwdata;
  logic              i_pready;
  logic [DATA_W-1:0] i_prdata;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [DATA_W-1:0] o_rsp_rdata;
  logic              o_rsp_last;
  logic              o_rsp_err;
  logic              o_busy;
  modport master (
    input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_cmd_len, i_pready, i_prdata, i_rsp_ready,
    output o_cmd_ready, o_penable, o_pwrite, o_paddr, o_pwdata, o_rsp_valid, o_rsp_rdata, o_rsp_last,
           o_rsp_err, o_busy
  );
  modport slave (
    output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_cmd_len, i_pready, i_prdata, i_rsp_ready,
    input  o_cmd_ready, o_penable, o_pwrite, o_paddr, o_pwdata, o_rsp_valid, o_rsp_rdata, o_rsp_last,
           o_rsp_err, o_busy
  );
endinterface

// File: rtl/cpu_mem_apb_master.sv
// cpu_mem_apb_master: burst command to APB beat sequencer with one registered response per beat.
// Optional ACCESS timeout enabled by CPU_MEM_APB_MASTER_TIMEOUT_EN.
module cpu_mem_apb_master
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int LEN_W          = LEN_W_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic i_clk,
  input logic i_rst,
  cpu_mem_apb_master_if.master bus
);
  state_e            state_q;
  logic              cmd_ready_q, penable_q, rsp_valid_q, write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [LEN_W-1:0]  rem_q;
  logic              unused_addr;
  assign unused_addr = |bus.i_cmd_addr[1:0];
`ifdef CPU_MEM_APB_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_q;
  logic            err_q;
  assign bus.o_rsp_err = err_q;
`else
  logic unused_to;
  assign unused_to = |32'(TIMEOUT_CYCLES);
  assign bus.o_rsp_err = 1'b0;
`endif
  assign bus.o_cmd_ready = cmd_ready_q;
  assign bus.o_busy      = ~cmd_ready_q;
  assign bus.o_penable   = penable_q;
  assign bus.o_pwrite    = write_q;
  assign bus.o_paddr     = addr_q;
  assign bus.o_pwdata    = wdata_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_rdata = rdata_q;
  assign bus.o_rsp_last  = rsp_valid_q && rem_q == '0;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rem_q       <= '0;
`ifdef CPU_MEM_APB_MASTER_TIMEOUT_EN
      to_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.i_cmd_valid) begin
          write_q     <= bus.i_cmd_write;
          addr_q      <= {bus.i_cmd_addr[ADDR_W-1:2], 2'b00};
          wdata_q     <= bus.i_cmd_wdata;
          rem_q       <= bus.i_cmd_len;
          cmd_ready_q <= 1'b0;
          penable_q   <= 1'b1;
          state_q     <= ACCESS;
`ifdef CPU_MEM_APB_MASTER_TIMEOUT_EN
          to_q        <= '0;
          err_q       <= 1'b0;
`endif
        end
        ACCESS: if (bus.i_pready) begin
          rdata_q     <= write_q ? '0 : bus.i_prdata;
          penable_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
`ifdef CPU_MEM_APB_MASTER_TIMEOUT_EN
        // Abort collapses the rest of the burst so the error beat is also the last one.
        else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_q     <= '0;
          err_q       <= 1'b1;
          rem_q       <= '0;
          penable_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end else to_q <= to_q + 1'b1;
`endif
        RESP: if (bus.i_rsp_ready) begin
          rsp_valid_q <= 1'b0;
          if (rem_q == '0) begin
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            rem_q     <= rem_q - 1'b1;
            addr_q    <= addr_q + ADDR_W'(WORD_STRIDE);
            penable_q <= 1'b1;
            state_q   <= ACCESS;
`ifdef CPU_MEM_APB_MASTER_TIMEOUT_EN
            to_q      <= '0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_mem_apb_master.sv
// tb_cpu_mem_apb_master: directed checks of beat sequencing, back-pressure, wrap, reset and timeout.
module tb_cpu_mem_apb_master;
  localparam logic [31:0] XK = 32'hA5A5A5A5;
  logic clk = 1'b0, rst = 1'b1;
  logic hang = 1'b0, force_rdy = 1'b0;
  int pen_cnt = 0;
  int n_cmp = 0, n_bad = 0;
  cpu_mem_apb_master_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) bus ();
  cpu_mem_apb_master #(.TIMEOUT_CYCLES(8)) dut (.i_clk(clk), .i_rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  // SRAM slave: one penable cycle for writes, two for reads; read data is address ^ XK.
  always @(posedge clk) pen_cnt <= bus.o_penable ? pen_cnt + 1 : 0;
  assign bus.i_pready = force_rdy || (!hang && bus.o_penable && (bus.o_pwrite || pen_cnt >= 1));
  assign bus.i_prdata = bus.o_paddr ^ XK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [7:0] l);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_write = w;
    bus.i_cmd_addr  = a;
    bus.i_cmd_wdata = d;
    bus.i_cmd_len   = l;
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic beat(input logic w, input logic [31:0] a, input logic [31:0] d, input logic l);
    check("acc_penable", bus.o_penable, 1);
    check("acc_paddr", bus.o_paddr, a);
    check("acc_pwrite", bus.o_pwrite, w);
    if (w) check("acc_pwdata", bus.o_pwdata, d);
    check("acc_busy", bus.o_busy, 1);
    check("acc_cmd_ready", bus.o_cmd_ready, 0);
    check("acc_rsp_valid", bus.o_rsp_valid, 0);
    if (!w) begin
      @(negedge clk);
      check("acc2_penable", bus.o_penable, 1);
    end
    @(negedge clk);
    check("rsp_penable", bus.o_penable, 0);
    check("rsp_valid", bus.o_rsp_valid, 1);
    check("rsp_rdata", bus.o_rsp_rdata, w ? 32'h0 : a ^ XK);
    check("rsp_last", bus.o_rsp_last, l);
    check("rsp_err", bus.o_rsp_err, 0);
    @(negedge clk);
  endtask

  initial begin
    int seen;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_write = 1'b0;
    bus.i_cmd_addr  = '0;
    bus.i_cmd_wdata = '0;
    bus.i_cmd_len   = '0;
    bus.i_rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", bus.o_cmd_ready, 1);
    check("rst_penable", bus.o_penable, 0);
    check("rst_rsp_valid", bus.o_rsp_valid, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_paddr", bus.o_paddr, 0);
    check("rst_pwrite", bus.o_pwrite, 0);
    check("rst_rdata", bus.o_rsp_rdata, 0);
    check("rst_last", bus.o_rsp_last, 0);
    check("rst_err", bus.o_rsp_err, 0);
    rst = 1'b0;
    @(negedge clk);
    force_rdy = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_pready_busy", bus.o_busy, 0);
    check("idle_pready_rsp", bus.o_rsp_valid, 0);
    force_rdy = 1'b0;
    // Single write
    issue(1'b1, 32'h0000_0010, 32'hDEADBEEF, 8'd0);
    beat(1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
    check("wr_done_ready", bus.o_cmd_ready, 1);
    check("wr_done_rsp", bus.o_rsp_valid, 0);
    // Read burst of four
    issue(1'b0, 32'h0000_0100, 32'h0, 8'd3);
    for (int b = 0; b < 4; b++) beat(1'b0, 32'h100 + 32'(4 * b), 32'h0, b == 3);
    check("rd_done_busy", bus.o_busy, 0);
    // Response back-pressure, with a stray pready while penable is low
    bus.i_rsp_ready = 1'b0;
    issue(1'b0, 32'h0000_0200, 32'h0, 8'd1);
    repeat (2) @(negedge clk);
    force_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", bus.o_rsp_valid, 1);
      check("bp_penable", bus.o_penable, 0);
      check("bp_rdata", bus.o_rsp_rdata, 32'h200 ^ XK);
      check("bp_last", bus.o_rsp_last, 0);
      check("bp_paddr", bus.o_paddr, 32'h200);
      @(negedge clk);
    end
    force_rdy = 1'b0;
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    beat(1'b0, 32'h204, 32'h0, 1'b1);
    // Address wrap with unaligned start
    issue(1'b1, 32'hFFFF_FFFE, 32'h1234_5678, 8'd1);
    beat(1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 1'b0);
    beat(1'b1, 32'h0000_0000, 32'h1234_5678, 1'b1);
    // Command presented while busy is held, not dropped
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_write = 1'b1;
    bus.i_cmd_addr  = 32'h40;
    bus.i_cmd_wdata = 32'hCAFE_0001;
    bus.i_cmd_len   = 8'd0;
    @(negedge clk);
    bus.i_cmd_write = 1'b0;
    bus.i_cmd_addr  = 32'h50;
    beat(1'b1, 32'h40, 32'hCAFE_0001, 1'b1);
    check("held_cmd_ready", bus.o_cmd_ready, 1);
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    beat(1'b0, 32'h50, 32'h0, 1'b1);
    // Reset during ACCESS of beat 2
    issue(1'b0, 32'h0000_0300, 32'h0, 8'd7);
    beat(1'b0, 32'h300, 32'h0, 1'b0);
    check("mid_paddr", bus.o_paddr, 32'h304);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_penable", bus.o_penable, 0);
    check("mrst_busy", bus.o_busy, 0);
    check("mrst_cmd_ready", bus.o_cmd_ready, 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.o_rsp_valid || bus.o_penable) seen++;
      @(negedge clk);
    end
    check("mrst_quiet", 32'(seen), 0);
`ifdef CPU_MEM_APB_MASTER_TIMEOUT_EN
    hang = 1'b1;
    issue(1'b0, 32'h0000_0400, 32'h0, 8'd3);
    for (int i = 0; i < 8; i++) begin
      check("to_penable", bus.o_penable, 1);
      check("to_rsp_valid", bus.o_rsp_valid, 0);
      @(negedge clk);
    end
    check("to_valid", bus.o_rsp_valid, 1);
    check("to_err", bus.o_rsp_err, 1);
    check("to_last", bus.o_rsp_last, 1);
    check("to_rdata", bus.o_rsp_rdata, 0);
    check("to_penable_off", bus.o_penable, 0);
    @(negedge clk);
    hang = 1'b0;
    check("to_idle_busy", bus.o_busy, 0);
    check("to_idle_ready", bus.o_cmd_ready, 1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
